line_fill_unit: RTL and testbench

- Sits directly downstream of the L1 cache and acts as the CPU's sole Avalon memory-mapped master.
- Takes one miss or write-through request from the cache at a time.
- Read misses: fetches the whole line critical-word-first, streaming each word back to the cache with its line index.
- Writes: performs a single-word Avalon write with byteenable.

---
 rtl/mem_pkg.sv | 31 +++
 rtl/line_fill_unit_if.sv | 46 ++++
 rtl/line_fill_unit.sv | 103 ++++++++++
 tb/tb_line_fill_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared memory-side types for the L1 cache and its line fill unit.
// The cache uses line_split for the same tag/index split.
package mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_CAP,
    WR_REQ,
    DONE
  } line_fill_state_t;

  localparam int WORD_BYTES = 4;

  typedef struct packed {
    logic [31:0] base;
    logic [31:0] idx;
  } line_split_t;

  // idx_w is log2(words per line); base clears the whole line offset
  function automatic line_split_t line_split(
    input logic [31:0] addr,
    input int          idx_w
  );
    logic [31:0] mask;
    mask = (32'd1 << (idx_w + 2)) - 32'd1;
    line_split.base = addr & ~mask;
    line_split.idx  = (addr & mask) >> 2;
  endfunction

endpackage

// File: rtl/line_fill_unit_if.sv
// Cache request / fill return and Avalon-MM master bundle.
// master: the line fill unit; slave: cache plus memory side.
interface line_fill_unit_if #(
  parameter int WORDS_PER_LINE = 4
);
  localparam int IDX_W = $clog2(WORDS_PER_LINE);

  logic             req_valid;
  logic             req_ready;
  logic             req_write;
  logic [31:0]      req_addr;
  logic [31:0]      req_wdata;
  logic [3:0]       req_byteenable;
  logic             fill_valid;
  logic [IDX_W-1:0] fill_idx;
  logic [31:0]      fill_data;
  logic             done;
  logic [31:0]      address;
  logic             read;
  logic             write;
  logic             waitrequest;
  logic [31:0]      writedata;
  logic [3:0]       byteenable;
  logic [31:0]      readdata;

  modport master (
    input  req_valid, req_write, req_addr,
    input  req_wdata, req_byteenable,
    output req_ready,
    output fill_valid, fill_idx, fill_data, done,
    output address, read, write,
    output writedata, byteenable,
    input  waitrequest, readdata
  );

  modport slave (
    output req_valid, req_write, req_addr,
    output req_wdata, req_byteenable,
    input  req_ready,
    input  fill_valid, fill_idx, fill_data, done,
    input  address, read, write,
    input  writedata, byteenable,
    output waitrequest, readdata
  );

endinterface

// File: rtl/line_fill_unit.sv
// Line fill unit: critical-word-first line fills and single-word
// write-through, acting as the sole Avalon-MM master.
module line_fill_unit
  import mem_pkg::*;
#(
  parameter int WORDS_PER_LINE = 4
) (
  input logic              clk,
  input logic              reset,
  line_fill_unit_if.master bus
);

  localparam int IDX_W = $clog2(WORDS_PER_LINE);

  line_fill_state_t state, state_nxt;
  line_split_t      split;

  logic [31:0]      base;
  logic [31:0]      idx;
  logic [IDX_W-1:0] cnt;
  logic [31:0]      wr_addr;
  logic [31:0]      wdata;
  logic [3:0]       be;
  logic             fire;
  logic             last;

  assign split = line_split(bus.req_addr, IDX_W);
  assign fire  = (state == IDLE) && bus.req_valid;
  assign last  = (cnt == IDX_W'(WORDS_PER_LINE - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      base    <= '0;
      idx     <= '0;
      cnt     <= '0;
      wr_addr <= '0;
      wdata   <= '0;
      be      <= '0;
    end else begin
      state <= state_nxt;
      if (fire) begin
        base    <= split.base;
        idx     <= split.idx;
        cnt     <= '0;
        wr_addr <= bus.req_addr & ~32'd3;
        wdata   <= bus.req_wdata;
        be      <= bus.req_byteenable;
      end else if (state == RD_CAP) begin
        // index wraps inside the line; base stays fixed
        idx <= (idx + 32'd1) & 32'(WORDS_PER_LINE - 1);
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    bus.req_ready  = 1'b0;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    bus.address    = '0;
    bus.writedata  = '0;
    bus.byteenable = '0;
    bus.fill_valid = 1'b0;
    bus.fill_idx   = '0;
    bus.fill_data  = '0;
    bus.done       = 1'b0;
    unique case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid)
          state_nxt = bus.req_write ? WR_REQ : RD_REQ;
      end
      RD_REQ: begin
        bus.read    = 1'b1;
        bus.address = base + (idx << 2);
        if (!bus.waitrequest)
          state_nxt = RD_CAP;
      end
      RD_CAP: begin
        bus.fill_valid = 1'b1;
        bus.fill_idx   = idx[IDX_W-1:0];
        bus.fill_data  = bus.readdata;
        state_nxt      = last ? DONE : RD_REQ;
      end
      WR_REQ: begin
        bus.write      = 1'b1;
        bus.address    = wr_addr;
        bus.writedata  = wdata;
        bus.byteenable = be;
        if (!bus.waitrequest)
          state_nxt = DONE;
      end
      DONE: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_line_fill_unit.sv
// Directed bench for line_fill_unit with a simple Avalon memory model.
// Memory returns address ^ 32'hA5A5_0000 for every accepted read.
module tb_line_fill_unit;

  localparam logic [31:0] PAT = 32'hA5A5_0000;

  logic clk;
  logic reset;
  int   n_assert;
  int   n_fail;
  int   fv_cnt;
  int   fv0;

  logic [31:0] exp_a [4];
  logic [31:0] exp_i [4];

  line_fill_unit_if #(.WORDS_PER_LINE(4)) bus ();

  line_fill_unit #(.WORDS_PER_LINE(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (bus.read && !bus.waitrequest)
      bus.readdata <= bus.address ^ PAT;

  always @(posedge clk)
    if (bus.fill_valid)
      fv_cnt <= fv_cnt + 1;

  always @(negedge clk)
    if (reset) begin
      n_assert++;
      assert (!(bus.read && bus.write)) else begin
        n_fail++;
        $error("FAIL rd_wr_excl: observed read=%b write=%b expected not both",
               bus.read, bus.write);
      end
    end

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered at the negedge of the first RD_REQ cycle; leaves at the
  // negedge of the IDLE cycle following DONE.
  task automatic fill(input int stall_word, input int stalls);
    fv0 = fv_cnt;
    for (int w = 0; w < 4; w++) begin
      int n;
      n = (w == stall_word) ? stalls : 0;
      for (int s = 0; s <= n; s++) begin
        bus.waitrequest = (s < n);
        chk("rd_read", 32'(bus.read), 32'd1);
        chk("rd_addr", bus.address, exp_a[w]);
        chk("rd_ready", 32'(bus.req_ready), 32'd0);
        chk("rd_fv", 32'(bus.fill_valid), 32'd0);
        chk("rd_done", 32'(bus.done), 32'd0);
        @(negedge clk);
      end
      bus.waitrequest = 1'b0;
      chk("cap_fv", 32'(bus.fill_valid), 32'd1);
      chk("cap_idx", 32'(bus.fill_idx), exp_i[w]);
      chk("cap_data", bus.fill_data, exp_a[w] ^ PAT);
      chk("cap_read", 32'(bus.read), 32'd0);
      chk("cap_done", 32'(bus.done), 32'd0);
      @(negedge clk);
    end
    chk("done", 32'(bus.done), 32'd1);
    chk("done_fv", 32'(bus.fill_valid), 32'd0);
    chk("done_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    chk("idle_done", 32'(bus.done), 32'd0);
    chk("idle_ready", 32'(bus.req_ready), 32'd1);
    chk("fv_pulses", 32'(fv_cnt - fv0), 32'd4);
  endtask

  initial begin
    n_assert           = 0;
    n_fail             = 0;
    fv_cnt             = 0;
    reset              = 1'b0;
    bus.req_valid      = 1'b0;
    bus.req_write      = 1'b0;
    bus.req_addr       = '0;
    bus.req_wdata      = '0;
    bus.req_byteenable = '0;
    bus.waitrequest    = 1'b0;
    bus.readdata       = '0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_read", 32'(bus.read), 32'd0);
    chk("rst_write", 32'(bus.write), 32'd0);
    chk("rst_fv", 32'(bus.fill_valid), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_addr", bus.address, 32'd0);
    chk("rst_wdata", bus.writedata, 32'd0);
    chk("rst_be", 32'(bus.byteenable), 32'd0);
    chk("rst_idx", 32'(bus.fill_idx), 32'd0);
    chk("rst_fdata", bus.fill_data, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'd1);

    // fill, no stalls
    exp_a = '{32'h1008, 32'h100C, 32'h1000, 32'h1004};
    exp_i = '{32'd2, 32'd3, 32'd0, 32'd1};
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_1008;
    @(negedge clk);
    bus.req_valid = 1'b0;
    fill(-1, 0);

    // fill with 3 stall cycles on the second word
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    fill(1, 3);

    // single-word write
    bus.req_valid      = 1'b1;
    bus.req_write      = 1'b1;
    bus.req_addr       = 32'h0000_2003;
    bus.req_wdata      = 32'hDEAD_BEEF;
    bus.req_byteenable = 4'b0110;
    fv0 = fv_cnt;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    chk("wr_write", 32'(bus.write), 32'd1);
    chk("wr_read", 32'(bus.read), 32'd0);
    chk("wr_addr", bus.address, 32'h0000_2000);
    chk("wr_data", bus.writedata, 32'hDEAD_BEEF);
    chk("wr_be", 32'(bus.byteenable), 32'h6);
    chk("wr_ready", 32'(bus.req_ready), 32'd0);
    chk("wr_done0", 32'(bus.done), 32'd0);
    @(negedge clk);
    chk("wr_done", 32'(bus.done), 32'd1);
    chk("wr_write_off", 32'(bus.write), 32'd0);
    @(negedge clk);
    chk("wr_idle", 32'(bus.req_ready), 32'd1);
    chk("wr_no_fv", 32'(fv_cnt - fv0), 32'd0);

    // wrap at the last word of the line
    exp_a = '{32'h300C, 32'h3000, 32'h3004, 32'h3008};
    exp_i = '{32'd3, 32'd0, 32'd1, 32'd2};
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_300C;
    @(negedge clk);
    bus.req_valid = 1'b0;
    fill(-1, 0);

    // back-pressure: second request held valid through the first fill
    exp_a = '{32'h4004, 32'h4008, 32'h400C, 32'h4000};
    exp_i = '{32'd1, 32'd2, 32'd3, 32'd0};
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_4004;
    @(negedge clk);
    bus.req_addr = 32'h0000_5000;
    fill(-1, 0);
    exp_a = '{32'h5000, 32'h5004, 32'h5008, 32'h500C};
    exp_i = '{32'd0, 32'd1, 32'd2, 32'd3};
    @(negedge clk);
    bus.req_valid = 1'b0;
    fill(-1, 0);
    @(negedge clk);
    chk("bp_no_dup", 32'(bus.read), 32'd0);
    chk("bp_idle", 32'(bus.req_ready), 32'd1);

    // reset while stalled in RD_REQ
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_6000;
    @(negedge clk);
    bus.req_valid   = 1'b0;
    bus.waitrequest = 1'b1;
    chk("mr_read", 32'(bus.read), 32'd1);
    chk("mr_addr", bus.address, 32'h0000_6000);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mr_read_off", 32'(bus.read), 32'd0);
    chk("mr_fv", 32'(bus.fill_valid), 32'd0);
    chk("mr_done", 32'(bus.done), 32'd0);
    reset           = 1'b1;
    bus.waitrequest = 1'b0;
    @(negedge clk);
    chk("mr_ready", 32'(bus.req_ready), 32'd1);
    chk("mr_done2", 32'(bus.done), 32'd0);
    chk("mr_read2", 32'(bus.read), 32'd0);
    @(negedge clk);
    chk("mr_done3", 32'(bus.done), 32'd0);
    chk("mr_fv3", 32'(bus.fill_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
